// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin share of one combinational ALU with a 1-entry tagged response slot
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int XLEN = 32,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_a,
  input  logic [NUM_REQ*XLEN-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]    req_sel,
  output logic [XLEN-1:0]         alu_a,
  output logic [XLEN-1:0]         alu_b,
  output logic [3:0]              alu_sel,
  input  logic [XLEN-1:0]         alu_o,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [XLEN-1:0]         rsp_data,
  output logic [IDW-1:0]          rsp_id
);

  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic           grant_any;
  logic           slot_free;
  logic           accept;

  // (base + off) mod NUM_REQ; base < NUM_REQ and off <= NUM_REQ so one subtraction suffices.
  function automatic logic [IDW-1:0] lane_at(input logic [IDW-1:0] base, input int unsigned off);
    logic [IDW:0] s;
    s = {1'b0, base} + (IDW+1)'(off);
    if (s >= (IDW+1)'(NUM_REQ)) s = s - (IDW+1)'(NUM_REQ);
    return s[IDW-1:0];
  endfunction

  assign slot_free = !rsp_valid || rsp_ready;

  // Search from the farthest offset down so the nearest valid lane after last_grant wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      cand = lane_at(last_grant, k);
      if (req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // rst blocks grants so no lane sees a handshake that the reset edge then discards.
  assign accept = slot_free && grant_any && !rst;

  always_comb begin
    req_ready = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_sel   = '0;
    if (accept) begin
      req_ready = NUM_REQ'(1) << grant_idx;
      alu_a     = req_a[int'(grant_idx)*XLEN +: XLEN];
      alu_b     = req_b[int'(grant_idx)*XLEN +: XLEN];
      alu_sel   = req_sel[int'(grant_idx)*4 +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      last_grant <= IDW'(NUM_REQ-1);
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_data   <= alu_o;
      rsp_id     <= grant_idx;
      last_grant <= grant_idx;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter with a behavioural ALU
module tb_alu_share_arbiter;

  localparam int N = 4;
  localparam int XL = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*XL-1:0] req_a;
  logic [N*XL-1:0] req_b;
  logic [N*4-1:0]  req_sel;
  logic [XL-1:0]   alu_a;
  logic [XL-1:0]   alu_b;
  logic [3:0]      alu_sel;
  logic [XL-1:0]   alu_o;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XL-1:0]   rsp_data;
  logic [1:0]      rsp_id;

  logic [XL-1:0] la [N];
  logic [XL-1:0] lb [N];
  logic [3:0]    ls [N];

  int errors = 0;
  int checks = 0;
  int m_last = N-1;
  int q_id[$];
  logic [XL-1:0] q_data[$];

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(N), .XLEN(XL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_o(alu_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  function automatic logic [XL-1:0] alu_f(input logic [XL-1:0] a, input logic [XL-1:0] b, input logic [3:0] s);
    case (s)
      4'h0: return a + b;
      4'h8: return a - b;
      4'h1: return a << b[4:0];
      4'h2: return {31'b0, $signed(a) < $signed(b)};
      4'h3: return {31'b0, a < b};
      4'h4: return a ^ b;
      4'h5: return a >> b[4:0];
      4'hd: return $unsigned($signed(a) >>> b[4:0]);
      4'h6: return a | b;
      4'h7: return a & b;
      default: return '0;
    endcase
  endfunction

  assign alu_o = alu_f(alu_a, alu_b, alu_sel);

  always_comb begin
    req_a   = '0;
    req_b   = '0;
    req_sel = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*XL +: XL] = la[i];
      req_b[i*XL +: XL] = lb[i];
      req_sel[i*4 +: 4] = ls[i];
    end
  end

  task automatic check_eq(input string tag, input logic [XL-1:0] got, input logic [XL-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs against the model at negedge, advance the model, return at posedge+1.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    g = -1;
    if (!rst && (q_id.size() == 0 || rsp_ready))
      for (int k = 1; k <= N; k++)
        if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    check_eq("req_ready", XL'(req_ready), XL'(exp_rdy));
    check_eq("alu_a", alu_a, (g >= 0) ? la[g] : '0);
    check_eq("alu_sel", XL'(alu_sel), (g >= 0) ? XL'(ls[g]) : '0);
    check_eq("rsp_valid", XL'(rsp_valid), XL'(q_id.size() != 0));
    if (q_id.size() != 0) begin
      check_eq("rsp_id", XL'(rsp_id), XL'(q_id[0]));
      check_eq("rsp_data", rsp_data, q_data[0]);
    end
    if (rst) begin
      q_id.delete();
      q_data.delete();
      m_last = N-1;
    end else begin
      if (q_id.size() != 0 && rsp_ready) begin
        void'(q_id.pop_front());
        void'(q_data.pop_front());
      end
      if (g >= 0) begin
        q_id.push_back(g);
        q_data.push_back(alu_f(la[g], lb[g], ls[g]));
        m_last = g;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [XL-1:0] frz;
    for (int i = 0; i < N; i++) begin
      la[i] = XL'(i + 1);
      lb[i] = XL'(i * 3);
      ls[i] = 4'h0;
    end
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b0;

    // Reset with all lanes requesting
    cycle();
    check_eq("rst_valid", XL'(rsp_valid), 0);
    check_eq("rst_data", rsp_data, 0);
    check_eq("rst_id", XL'(rsp_id), 0);
    cycle();
    rst = 1'b0;
    #1 check_eq("first_grant", XL'(req_ready), 1);
    cycle();
    req_valid = '0;
    rsp_ready = 1'b1;
    cycle();

    // Single op on lane 2
    la[2] = 5; lb[2] = 3; ls[2] = 4'h0;
    req_valid = 4'b0100;
    #1 check_eq("t2_ready", XL'(req_ready), 4);
    cycle();
    check_eq("t2_valid", XL'(rsp_valid), 1);
    check_eq("t2_data", rsp_data, 8);
    check_eq("t2_id", XL'(rsp_id), 2);

    // Subtract and signed compare on lane 1
    la[1] = 10; lb[1] = 3; ls[1] = 4'b1000;
    req_valid = 4'b0010;
    cycle();
    check_eq("t3_sub", rsp_data, 7);
    la[1] = '1; lb[1] = 1; ls[1] = 4'b0010;
    cycle();
    check_eq("t3_slt", rsp_data, 1);
    req_valid = '0;
    cycle();

    // Round-robin from reset, one per cycle
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check_eq("rr_id", XL'(rsp_id), XL'(k % N));
      check_eq("rr_valid", XL'(rsp_valid), 1);
    end

    // Backpressure then drain with same-cycle accept
    rsp_ready = 1'b0;
    frz = rsp_data;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("bp_data", rsp_data, frz);
      check_eq("bp_id", XL'(rsp_id), 3);
    end
    rsp_ready = 1'b1;
    cycle();
    check_eq("bp_next_id", XL'(rsp_id), 0);
    check_eq("bp_next_valid", XL'(rsp_valid), 1);

    // Reset while backpressured
    rsp_ready = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_eq("mid_rst_valid", XL'(rsp_valid), 0);
    rsp_ready = 1'b1;
    cycle();
    check_eq("mid_rst_grant", XL'(rsp_id), 0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        la[i] = $urandom;
        lb[i] = $urandom;
        ls[i] = 4'($urandom_range(0, 15));
      end
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
